// File: rtl/enigma_keyer.sv
// Enigma stepping controller: accepts a letter, pulses the rotor steps (with the
// middle-rotor double step), captures the chain result and hands it to the consumer.
module enigma_keyer #(
  parameter logic [4:0] NOTCH_R = 5'd16,
  parameter logic [4:0] NOTCH_M = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_config,
  input  logic [4:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [4:0]  pos_r,
  input  logic [4:0]  pos_m,
  output logic        rotors_load,
  output logic        step_r,
  output logic        step_m,
  output logic        step_l,
  output logic [4:0]  char_to_chain,
  input  logic [4:0]  cipher_in,
  output logic [4:0]  char_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err_pulse,
  output logic [15:0] char_count
);

  typedef enum logic [1:0] {IDLE, STEP, EVAL, OUT} state_t;

  state_t state, state_nxt;
  logic   accept;

  function automatic logic letter_ok(input logic [4:0] c);
    return c <= 5'd25;
  endfunction

  assign char_ready = (state == IDLE) && !load_config;
  assign accept     = char_valid && char_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && letter_ok(char_in)) state_nxt = STEP;
      STEP:    state_nxt = EVAL;
      EVAL:    state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Step decisions use the pre-step positions, which the rotors still present during STEP.
  always_comb begin
    step_r      = 1'b0;
    step_m      = 1'b0;
    step_l      = 1'b0;
    rotors_load = 1'b0;
    if (state == STEP) begin
      step_r = 1'b1;
      step_m = (pos_r == NOTCH_R) || (pos_m == NOTCH_M);
      step_l = (pos_m == NOTCH_M);
    end
    if (state == IDLE && reset && load_config) rotors_load = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      char_to_chain <= 5'd0;
      char_out      <= 5'd0;
      out_valid     <= 1'b0;
      err_pulse     <= 1'b0;
      char_count    <= 16'd0;
    end else begin
      err_pulse <= 1'b0;
      if (state == IDLE && load_config) char_count <= 16'd0;
      if (accept) begin
        if (letter_ok(char_in)) char_to_chain <= char_in;
        else                    err_pulse     <= 1'b1;
      end
      if (state == EVAL) begin
        char_out  <= cipher_in;
        out_valid <= 1'b1;
      end
      if (state == OUT && out_ready) begin
        out_valid  <= 1'b0;
        char_count <= char_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_enigma_keyer.sv
// Bench for enigma_keyer: emulated rotors plus a toy chain, letters checked
// against positions and step rules computed arithmetically per letter.
module tb_enigma_keyer;

  localparam int NR = 16;
  localparam int NM = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_config = 1'b0;
  logic [4:0]  char_in = 5'd0;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [4:0]  pos_r = 5'd0, pos_m = 5'd0, pos_l = 5'd0;
  logic        rotors_load, step_r, step_m, step_l;
  logic [4:0]  char_to_chain;
  logic [4:0]  cipher_in;
  logic [4:0]  char_out;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        err_pulse;
  logic [15:0] char_count;

  logic        preset_req = 1'b0;
  logic [4:0]  preset_r = 5'd0, preset_m = 5'd0, preset_l = 5'd0;

  int n_checks = 0;
  int n_errors = 0;
  int m_count  = 0;

  enigma_keyer #(.NOTCH_R(5'd16), .NOTCH_M(5'd4)) dut (
    .clk(clk), .reset(reset), .load_config(load_config),
    .char_in(char_in), .char_valid(char_valid), .char_ready(char_ready),
    .pos_r(pos_r), .pos_m(pos_m), .rotors_load(rotors_load),
    .step_r(step_r), .step_m(step_m), .step_l(step_l),
    .char_to_chain(char_to_chain), .cipher_in(cipher_in),
    .char_out(char_out), .out_valid(out_valid), .out_ready(out_ready),
    .err_pulse(err_pulse), .char_count(char_count)
  );

  always #5 clk = ~clk;

  function automatic int cipher_of(input int c, input int pr, input int pm, input int pl);
    return (c + 3 * pr + 5 * pm + pl) % 26;
  endfunction

  assign cipher_in = 5'(cipher_of(int'(char_to_chain), int'(pos_r), int'(pos_m), int'(pos_l)));

  // Rotor emulation: the rotors own their own 25->0 wrap.
  always @(posedge clk) begin
    if (preset_req) begin
      pos_r <= preset_r;
      pos_m <= preset_m;
      pos_l <= preset_l;
    end else begin
      if (step_r) pos_r <= (pos_r == 5'd25) ? 5'd0 : pos_r + 5'd1;
      if (step_m) pos_m <= (pos_m == 5'd25) ? 5'd0 : pos_m + 5'd1;
      if (step_l) pos_l <= (pos_l == 5'd25) ? 5'd0 : pos_l + 5'd1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send(input int c, input int pr, input int pm, input int pl, input int hold);
    int npr, npm, npl, exp_out;
    bit em, el;
    @(negedge clk);
    preset_req = 1'b1;
    preset_r = 5'(pr); preset_m = 5'(pm); preset_l = 5'(pl);
    @(negedge clk);
    preset_req = 1'b0;
    check("ready_idle", char_ready, 1);
    char_in = 5'(c);
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    if (c > 25) begin
      check("err_pulse", err_pulse, 1);
      check("err_no_step", {step_r, step_m, step_l}, 0);
      @(negedge clk);
      check("err_once", err_pulse, 0);
      check("err_no_step2", {step_r, step_m, step_l}, 0);
      check("err_count", char_count, m_count);
      check("err_idle", char_ready, 1);
      return;
    end
    em = (pr == NR) || (pm == NM);
    el = (pm == NM);
    check("step_r", step_r, 1);
    check("step_m", step_m, em);
    check("step_l", step_l, el);
    check("err_quiet", err_pulse, 0);
    npr = (pr + 1) % 26;
    npm = em ? (pm + 1) % 26 : pm;
    npl = el ? (pl + 1) % 26 : pl;
    exp_out = cipher_of(c, npr, npm, npl);
    @(negedge clk);
    check("step_single", {step_r, step_m, step_l}, 0);
    check("eval_nvld", out_valid, 0);
    check("chain_hold", char_to_chain, c);
    @(negedge clk);
    check("out_valid", out_valid, 1);
    check("char_out", char_out, exp_out);
    for (int i = 0; i < hold; i++) begin
      char_valid  = 1'b1;
      char_in     = 5'($urandom_range(0, 25));
      load_config = 1'($urandom_range(0, 1));
      #1;
      check("ld_ignored", rotors_load, 0);
      check("hold_nready", char_ready, 0);
      @(negedge clk);
      check("hold_vld", out_valid, 1);
      check("hold_char", char_out, exp_out);
      check("hold_nostep", {step_r, step_m, step_l}, 0);
    end
    char_valid  = 1'b0;
    load_config = 1'b0;
    out_ready   = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    m_count = (m_count + 1) % 65536;
    check("done_nvld", out_valid, 0);
    check("count", char_count, m_count);
    check("done_ready", char_ready, 1);
  endtask

  task automatic do_load();
    @(negedge clk);
    load_config = 1'b1;
    #1;
    check("rotors_load", rotors_load, 1);
    check("ld_nready", char_ready, 0);
    @(negedge clk);
    load_config = 1'b0;
    #1;
    m_count = 0;
    check("load_once", rotors_load, 0);
    check("load_clear", char_count, 0);
  endtask

  task automatic reset_in_eval();
    @(negedge clk);
    preset_req = 1'b1;
    preset_r = 5'd16; preset_m = 5'd4; preset_l = 5'd9;
    @(negedge clk);
    preset_req = 1'b0;
    char_in = 5'd3;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_vld", out_valid, 0);
    check("rst_char", char_out, 0);
    check("rst_chain", char_to_chain, 0);
    check("rst_count", char_count, 0);
    check("rst_err", err_pulse, 0);
    check("rst_step", {step_r, step_m, step_l}, 0);
    @(negedge clk);
    reset = 1'b1;
    m_count = 0;
    check("rel_ready", char_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rel_nvld", out_valid, 0);
      check("rel_nostep", {step_r, step_m, step_l}, 0);
    end
  endtask

  initial begin
    #2 reset = 1'b0;
    #1;
    check("init_vld", out_valid, 0);
    check("init_count", char_count, 0);
    check("init_step", {step_r, step_m, step_l, rotors_load}, 0);
    check("init_chain", char_to_chain, 0);
    check("init_err", err_pulse, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("init_ready", char_ready, 1);

    send(0, 0, 0, 0, 0);
    send(7, 16, 0, 2, 1);
    send(12, 5, 4, 11, 0);
    send(25, 16, 4, 25, 2);
    send(19, 25, 25, 25, 10);
    send(27, 16, 4, 0, 0);
    do_load();
    send(1, 3, 4, 7, 0);
    reset_in_eval();

    for (int k = 0; k < 40; k++) begin
      int c, pr, pm, pl;
      c  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(26, 31)) : int'($urandom_range(0, 25));
      pr = ($urandom_range(0, 3) == 0) ? NR : int'($urandom_range(0, 25));
      pm = ($urandom_range(0, 3) == 0) ? NM : int'($urandom_range(0, 25));
      pl = int'($urandom_range(0, 25));
      send(c, pr, pm, pl, int'($urandom_range(0, 3)));
      if (k == 20) do_load();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/enigma_keyer.md
ENIGMA_KEYER -- requirements
Module: enigma_keyer

Interface
REQ-001 Parameter NOTCH_R, default 5'd16, right-rotor notch position (Q).
REQ-002 Parameter NOTCH_M, default 5'd4, middle-rotor notch position (E).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 load_config  input  1  request to load rotor start positions.
REQ-006 char_in  input  5  plaintext letter, 0..25 = A..Z.
REQ-007 char_valid  input  1  char_in valid.
REQ-008 char_ready  output  1  controller can accept char_in.
REQ-009 pos_r, pos_m  input  5 each  current positions of right and middle rotors.
REQ-010 rotors_load  output  1  load_config pulse to all rotors.
REQ-011 step_r, step_m, step_l  output  1 each  step_enable to right/middle/left rotor.
REQ-012 char_to_chain  output  5  registered letter driving the right rotor char_in_fwd.
REQ-013 cipher_in  input  5  combinational result returning from the rotor/reflector chain.
REQ-014 char_out  output  5  registered ciphertext letter.
REQ-015 out_valid  output  1  char_out valid.  out_ready  input  1  consumer accepts char_out.
REQ-016 err_pulse  output  1  one-cycle flag: invalid letter dropped.
REQ-017 char_count  output  16  number of completed encryptions.

Function
REQ-018 FSM states IDLE, STEP, EVAL, OUT; only IDLE accepts input.
REQ-019 char_ready = (state==IDLE) && !load_config.
REQ-020 IDLE with load_config=1: rotors_load high for exactly that cycle (combinational pass-through, IDLE only), char_count cleared next edge, state stays IDLE.
REQ-021 load_config outside IDLE is ignored; rotors_load stays 0.
REQ-022 Accept = char_valid && char_ready; on accept with char_in<=25, char_to_chain <= char_in, state -> STEP.
REQ-023 Accept with char_in>=26: letter dropped, err_pulse=1 next cycle only, no steps, state stays IDLE.
REQ-024 STEP (exactly one cycle): step_r=1; step_m=1 iff pos_r==NOTCH_R or pos_m==NOTCH_M; step_l=1 iff pos_m==NOTCH_M; all evaluated on pre-step positions; state -> EVAL.
REQ-025 step_* are 0 in every state except STEP.
REQ-026 EVAL (one cycle, rotors hold new positions, chain settles): at its closing edge char_out <= cipher_in, out_valid <= 1, state -> OUT.
REQ-027 OUT: char_out and out_valid held stable while out_ready=0; on out_ready=1, out_valid <= 0, char_count <= char_count+1 (wraps 65535->0), state -> IDLE.
REQ-028 Latency: accept edge E0, step pulse cycle E0..E1, out_valid high from E2; minimum throughput one letter per 4 cycles.
REQ-029 char_to_chain held constant from accept until next accept.
REQ-030 Rotor position wrap (25->0) is owned by the rotors; controller compares raw 5-bit positions only.

Reset
REQ-031 reset=0 asynchronously forces state IDLE, char_to_chain=0, char_out=0, out_valid=0, err_pulse=0, char_count=0, all step_* and rotors_load=0.
REQ-032 Reset asserted mid-operation (STEP/EVAL/OUT) abandons the letter; no step pulse after reset release until a new accept.
REQ-033 char_ready=1 in the first cycle after reset release when load_config=0.

Verification
REQ-034 pos_r=0,pos_m=0, send char_in=0 -> step_r only pulses one cycle, out_valid high 2 cycles after accept, char_out=cipher_in value seen in EVAL.
REQ-035 pos_r=16,pos_m=0, send letter -> step_r and step_m pulse same cycle, step_l=0.
REQ-036 pos_r=5,pos_m=4 -> step_r, step_m, step_l all pulse (double step); pos_r=16,pos_m=4 -> same three, single pulse each.
REQ-037 out_ready=0 for 10 cycles -> char_out/out_valid stable, char_ready=0, char_valid ignored; out_ready=1 -> char_count+1, IDLE.
REQ-038 char_in=27 accepted -> err_pulse one cycle, no step_*, char_count unchanged; load_config in IDLE -> rotors_load one cycle, char_count=0.
REQ-039 reset=0 during EVAL -> all outputs zero immediately, no out_valid after release.
